control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Moore control sequencer for a fetch/execute datapath: states T0..T9 plus HALT.
// The execution path is decoded from the instruction opcode in ir[31:27].
module control_sequencer #(
    parameter logic [4:0] ADD_OP  = 5'b00011,
    parameter logic [4:0] NOP_OP  = 5'b11010,
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
    output logic        run,
    output logic [2:0]  gsel,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        read,
    output logic        RAMwrite,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Out_portIn,
    output logic        CONin,
    output logic [4:0]  opcode
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, HALT} state_t;
    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls;
    logic [4:0] op;
    logic       gra, grb, grc;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];

    // Instruction class; the parameterised NOP/HALT opcodes take priority.
    always_comb begin
        cls = C_NOP;
        if (op == HALT_OP)                      cls = C_HALT;
        else if (op == NOP_OP)                  cls = C_NOP;
        else if (op >= 5'd3  && op <= 5'd11)    cls = C_ALU;
        else if (op >= 5'd12 && op <= 5'd14)    cls = C_IMM;
        else if (op == 5'd15 || op == 5'd16)    cls = C_MULDIV;
        else if (op == 5'd17 || op == 5'd18)    cls = C_UNARY;
        else if (op == 5'd0)                    cls = C_LD;
        else if (op == 5'd1)                    cls = C_LDI;
        else if (op == 5'd2)                    cls = C_ST;
        else if (op == 5'd19)                   cls = C_BR;
        else if (op == 5'd20)                   cls = C_JR;
        else if (op == 5'd22)                   cls = C_IN;
        else if (op == 5'd23)                   cls = C_OUT;
        else if (op == 5'd24)                   cls = C_MFHI;
        else if (op == 5'd25)                   cls = C_MFLO;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= T0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        run = 1'b1; opcode = ADD_OP;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; IRin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; read = 1'b0; RAMwrite = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        InPortout = 1'b0; Out_portIn = 1'b0; CONin = 1'b0;
        case (state_q)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                state_d = stop ? HALT : T1;
            end
            T1: begin read = 1'b1; state_d = T2; end
            T2: begin read = 1'b1; MDRin = 1'b1; state_d = T3; end
            T3: begin MDRout = 1'b1; IRin = 1'b1; state_d = T4; end
            T4: begin
                state_d = T0;
                case (cls)
                    C_ALU, C_IMM: begin grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = T5; end
                    C_MULDIV:     begin gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = T5; end
                    C_UNARY: begin
                        grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; state_d = T5;
                    end
                    C_LD, C_LDI, C_ST: begin grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = T5; end
                    C_BR:   begin gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = T5; end
                    C_JR:   begin gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_IN:   begin InPortout = 1'b1; gra = 1'b1; Rin = 1'b1; end
                    C_OUT:  begin gra = 1'b1; Rout = 1'b1; Out_portIn = 1'b1; end
                    C_MFHI: begin HIout = 1'b1; gra = 1'b1; Rin = 1'b1; end
                    C_MFLO: begin LOout = 1'b1; gra = 1'b1; Rin = 1'b1; end
                    C_HALT: state_d = HALT;
                    default: ;
                endcase
            end
            T5: begin
                state_d = T0;
                case (cls)
                    C_ALU:    begin grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; state_d = T6; end
                    C_IMM:    begin Cout = 1'b1; Zin = 1'b1; opcode = op; state_d = T6; end
                    C_MULDIV: begin grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; state_d = T6; end
                    C_UNARY:  begin Zlowout = 1'b1; gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; state_d = T6; end
                    C_BR:     begin PCout = 1'b1; Yin = 1'b1; state_d = T6; end
                    default: ;
                endcase
            end
            T6: begin
                state_d = T0;
                case (cls)
                    C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; gra = 1'b1; Rin = 1'b1; end
                    C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; state_d = T7; end
                    C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; state_d = T7; end
                    C_BR:       begin Cout = 1'b1; Zin = 1'b1; state_d = T7; end
                    default: ;
                endcase
            end
            T7: begin
                state_d = T0;
                case (cls)
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    C_LD:     begin read = 1'b1; state_d = T8; end
                    C_ST:     begin gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = T8; end
                    // Branch target is taken only when the latched condition holds.
                    C_BR:     begin Zlowout = con; PCin = con; end
                    default: ;
                endcase
            end
            T8: begin
                state_d = T0;
                case (cls)
                    C_LD: begin read = 1'b1; MDRin = 1'b1; state_d = T9; end
                    C_ST: RAMwrite = 1'b1;
                    default: ;
                endcase
            end
            T9: begin
                state_d = T0;
                if (cls == C_LD) begin MDRout = 1'b1; gra = 1'b1; Rin = 1'b1; end
            end
            HALT: run = 1'b0;
            default: state_d = T0;
        endcase
        gsel = {gra, grb, grc};
    end

endmodule
